// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the holder pulses done or drops its request. Every
// release is followed by exactly one IDLE cycle before the next grant, and the
// search for the next winner starts just after the previous holder.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant is also
// revoked after HOLD_MAX cycles and tout pulses as the grant drops.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       any_req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic       tout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Reject an unusable hold limit at elaboration time.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_8: HOLD_MAX must be in 1..255");
  end

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic       grant_valid_q, grant_valid_d;
  logic [2:0] grant_id_q, grant_id_d;

  logic       found;
  logic [2:0] idx;
  logic [2:0] pick_id;
  logic       holder_drop;
  logic       hold_expired;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       tout_q, tout_d;

  // The grant is revoked on the edge where the counter shows HOLD_MAX-1,
  // which gives the holder exactly HOLD_MAX cycles.
  assign hold_expired = (hold_cnt_q == 8'(HOLD_MAX - 1));
  assign tout         = tout_q;
`else
  assign hold_expired = 1'b0;
  assign tout         = 1'b0;
`endif

  assign any_req     = |req;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign holder_drop = ~req[grant_id_q];

  // Pick the first active requester, searching upward from ptr and wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    found   = 1'b0;
    idx     = '0;
    pick_id = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

  // Next-state and output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    tout_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // done is ignored here: only requests start a grant.
        if (any_req) begin
          state_d       = BUSY;
          grant_d       = 8'b1 << pick_id;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_id;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        // Other requesters cannot disturb the grant; only the holder's own
        // done or request drop (or the timeout) ends it.
        if (done || holder_drop || hold_expired) begin
          state_d       = IDLE;
          ptr_d         = grant_id_q + 3'd1;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
`ifdef ARB_TIMEOUT_EN
          // A normal release on the same edge wins over the timeout.
          tout_d        = hold_expired && !done && !holder_drop;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any grant immediately and restarts the search at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
      tout_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the
      // same pre-edge values, independent of statement order.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      tout_q        <= tout_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed self-checking bench for rr_arbiter_8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The DUT is built with HOLD_MAX=4; timeout expectations follow ARB_TIMEOUT_EN.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       any_req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       tout;

  int total;
  int bad;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .any_req     (any_req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .tout        (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check the full registered grant view against an expected holder (or none).
  task automatic check_grant(input string tag, input logic vld, input logic [2:0] id);
    logic [7:0] exp_g;
    exp_g = vld ? (8'b1 << id) : 8'h00;
    check({tag, ".grant"}, 32'(grant), 32'(exp_g));
    check({tag, ".valid"}, 32'(grant_valid), 32'(vld));
    check({tag, ".id"}, 32'(grant_id), vld ? 32'(id) : 32'd0);
  endtask

  logic [7:0] exp_g_seq [6];
  logic       exp_t_seq [6];
  logic [7:0] v;
  logic [7:0] low;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;

    // Reset state with every requester active.
    repeat (2) @(negedge clk);
    check_grant("reset", 1'b0, 3'd0);
    check("reset.any_req", 32'(any_req), 32'd1);
    check("reset.tout", 32'(tout), 32'd0);

    // First grant one cycle after reset release goes to requester 0.
    rst_n = 1'b1;
    step();
    check_grant("first", 1'b1, 3'd0);

    // Rotation 0..7,0 with one IDLE cycle between grants.
    for (int i = 0; i < 9; i++) begin
      check_grant($sformatf("rot%0d", i), 1'b1, 3'(i % 8));
      done = 1'b1;
      step();
      check_grant($sformatf("rot%0d.gap", i), 1'b0, 3'd0);
      done = 1'b0;
      step();
    end

    // Now holding 1; release through 2,3,4 to reach holder 5.
    for (int i = 1; i < 5; i++) begin
      done = 1'b1;
      step();
      done = 1'b0;
      step();
    end
    check_grant("at5", 1'b1, 3'd5);

    // Skip and wrap: ptr becomes 6, requests 0 and 2 only.
    req  = 8'b0000_0101;
    done = 1'b1;
    step();
    check_grant("wrap.gap", 1'b0, 3'd0);
    done = 1'b0;
    step();
    check_grant("wrap.first", 1'b1, 3'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    check_grant("wrap.second", 1'b1, 3'd2);

    // Holder drop: get 3 granted with 4 also pending, then drop req[3].
    req  = 8'h18;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    check_grant("drop.hold3", 1'b1, 3'd3);
    req = 8'h10;
    step();
    check_grant("drop.gap", 1'b0, 3'd0);
    step();
    check_grant("drop.next4", 1'b1, 3'd4);

    // Other requests appearing while busy leave the grant alone.
    req = 8'hFF;
    step();
    check_grant("busy.stable", 1'b1, 3'd4);

    // done in IDLE is ignored: a new request is still granted.
    req  = 8'h00;
    done = 1'b1;
    step();
    check_grant("idle.rel", 1'b0, 3'd0);
    check("idle.any_req", 32'(any_req), 32'd0);
    step();
    check_grant("idle.noreq", 1'b0, 3'd0);
    req = 8'h08;
    step();
    check_grant("idle.done_ignored", 1'b1, 3'd3);
    step();
    check_grant("idle.done_rel", 1'b0, 3'd0);
    done = 1'b0;

    // Single requester 4 held with done low: timeout or indefinite hold.
    req = 8'h10;
    step();
    check_grant("hold.start", 1'b1, 3'd4);
`ifdef ARB_TIMEOUT_EN
    exp_g_seq = '{8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10};
    exp_t_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_g_seq = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    exp_t_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("hold%0d.grant", i), 32'(grant), 32'(exp_g_seq[i]));
      check($sformatf("hold%0d.tout", i), 32'(tout), 32'(exp_t_seq[i]));
    end

    // Single requester regranted after each done pulse.
    for (int i = 0; i < 2; i++) begin
      done = 1'b1;
      step();
      check_grant($sformatf("single%0d.gap", i), 1'b0, 3'd0);
      done = 1'b0;
      step();
      check_grant($sformatf("single%0d.regrant", i), 1'b1, 3'd4);
    end

    // Asynchronous reset mid-grant, then search restarts at requester 0.
    req   = 8'h81;
    #1;
    rst_n = 1'b0;
    #1;
    check_grant("async_rst", 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_grant("post_rst", 1'b1, 3'd0);

    // Sweep all request patterns from a fresh IDLE state.
    for (int i = 0; i < 256; i++) begin
      v     = 8'(i);
      low   = v & (~v + 8'd1);
      rst_n = 1'b0;
      req   = v;
      #1;
      check($sformatf("sweep%0d.any_req", i), 32'(any_req), 32'(v != 8'h00));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check($sformatf("sweep%0d.grant", i), 32'(grant), 32'(low));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
